// File: rtl/traffic_pkg.sv
// Shared state encoding and round-robin slot picker for traffic_phase_ctrl.
// Slot vectors are sized for the largest legal configuration (8 phases + pedestrian).
package traffic_pkg;

    localparam int MAX_SLOTS = 9;
    localparam int SLOT_W    = 4;
    localparam int IDX_W     = SLOT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_ALLRED = 3'd3,
        ST_WALK   = 3'd4,
        ST_CLEAR  = 3'd5
    } tl_state_e;

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
    } rr_pick_t;

    // Scans start+1, start+2, ... circularly over nslots entries; start itself is
    // visited last. Iterating downwards lets the nearest hit overwrite the others.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SLOTS-1:0] req,
        input logic [SLOT_W-1:0]    start,
        input logic [SLOT_W-1:0]    nslots
    );
        rr_pick_t         res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = MAX_SLOTS; i >= 1; i--) begin
            idx = {1'b0, start} + IDX_W'(i);
            if (idx >= {1'b0, nslots}) begin
                idx = idx - {1'b0, nslots};
            end
            if ((IDX_W'(i) <= {1'b0, nslots}) && req[idx[SLOT_W-1:0]]) begin
                res.valid = 1'b1;
                res.slot  = idx[SLOT_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter of timebase ticks; the controller clears it on every
// state change so each phase starts counting from zero.
module phase_timer #(
    parameter int TIMER_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               tick,
    output logic [TIMER_W-1:0] count
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection controller: round-robin over vehicle phases plus one
// latched pedestrian slot. Define TRAFFIC_ALLRED_EN to add an all-red interval.
//
// state  | meaning
// IDLE   | nothing requested, all red
// GREEN  | phase active_slot has right of way
// YELLOW | phase active_slot is ending
// ALLRED | all-red interval after YELLOW/CLEAR (TRAFFIC_ALLRED_EN only)
// WALK   | pedestrians may cross
// CLEAR  | pedestrian clearance, dont_walk flashing
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = 3,
    parameter int TIMER_W     = 8,
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 10,
    parameter int YELLOW_TIME = 3,
    parameter int WALK_TIME   = 6,
    parameter int CLEAR_TIME  = 4,
    parameter int ALLRED_TIME = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              tick,
    input  logic [NUM_PHASES-1:0]             car_req,
    input  logic                              ped_button,
    output logic [NUM_PHASES-1:0]             red,
    output logic [NUM_PHASES-1:0]             yellow,
    output logic [NUM_PHASES-1:0]             green,
    output logic                              walk,
    output logic                              dont_walk,
    output logic                              clearing,
    output logic                              ped_pending,
    output logic [$clog2(NUM_PHASES+1)-1:0]   active_slot
);

    localparam int SAW = $clog2(NUM_PHASES + 1);
    localparam logic [SAW-1:0] PED_SLOT = SAW'(NUM_PHASES);

    tl_state_e             state_q, state_d;
    logic [SAW-1:0]        slot_q, slot_d;
    logic                  ped_q, ped_d;
    logic [NUM_PHASES-1:0] red_q, yellow_q, green_q;
    logic [NUM_PHASES-1:0] red_d, yellow_d, green_d, sel_d;
    logic                  walk_q, dont_walk_q, clearing_q;
    logic                  walk_d, dont_walk_d, clearing_d;

    logic [TIMER_W-1:0]    timer;
    logic [MAX_SLOTS-1:0]  req;
    rr_pick_t              pick;
    logic                  go_pick;
    logic                  timer_clear;
    logic                  walk_entry;
    logic                  car_now;
    logic                  min_met, max_hit;
    logic                  yellow_done, walk_done, clear_done, allred_done;

    always_comb begin
        req = '0;
        req[NUM_PHASES:0] = {ped_q, car_req};
    end

    assign pick    = rr_pick(req, SLOT_W'(slot_q), SLOT_W'(NUM_PHASES + 1));
    assign car_now = req[SLOT_W'(slot_q)];

    assign min_met     = timer >= TIMER_W'(GREEN_MIN);
    assign max_hit     = tick && (timer == TIMER_W'(GREEN_MAX - 1));
    assign yellow_done = tick && (timer == TIMER_W'(YELLOW_TIME - 1));
    assign walk_done   = tick && (timer == TIMER_W'(WALK_TIME - 1));
    assign clear_done  = tick && (timer == TIMER_W'(CLEAR_TIME - 1));
    assign allred_done = tick && (timer == TIMER_W'(ALLRED_TIME - 1));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        go_pick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                go_pick = 1'b1;
            end
            ST_GREEN: begin
                if ((min_met && !car_now) || max_hit) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (yellow_done) begin
`ifdef TRAFFIC_ALLRED_EN
                    state_d = ST_ALLRED;
`else
                    go_pick = 1'b1;
`endif
                end
            end
            // Unreachable without TRAFFIC_ALLRED_EN; still exits sensibly.
            ST_ALLRED: begin
                if (allred_done) begin
                    go_pick = 1'b1;
                end
            end
            ST_WALK: begin
                if (walk_done) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clear_done) begin
`ifdef TRAFFIC_ALLRED_EN
                    state_d = ST_ALLRED;
`else
                    go_pick = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = PED_SLOT;
            end
        endcase

        if (go_pick) begin
            if (!pick.valid) begin
                state_d = ST_IDLE;
                slot_d  = PED_SLOT;
            end else begin
                slot_d  = SAW'(pick.slot);
                state_d = (SAW'(pick.slot) == PED_SLOT) ? ST_WALK : ST_GREEN;
            end
        end
    end

    assign timer_clear = (state_d != state_q);
    assign walk_entry  = (state_d == ST_WALK) && (state_q != ST_WALK);
    // A press coinciding with WALK entry survives for the next pedestrian turn.
    assign ped_d       = ped_button | (ped_q & ~walk_entry);

    always_comb begin
        sel_d       = NUM_PHASES'(1) << slot_d;
        red_d       = '1;
        yellow_d    = '0;
        green_d     = '0;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        clearing_d  = 1'b0;
        case (state_d)
            ST_GREEN: begin
                green_d = sel_d;
                red_d   = ~sel_d;
            end
            ST_YELLOW: begin
                yellow_d = sel_d;
                red_d    = ~sel_d;
            end
            ST_WALK: begin
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
            end
            ST_CLEAR: begin
                clearing_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            slot_q      <= PED_SLOT;
            ped_q       <= 1'b0;
            red_q       <= '1;
            yellow_q    <= '0;
            green_q     <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            clearing_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            ped_q       <= ped_d;
            red_q       <= red_d;
            yellow_q    <= yellow_d;
            green_q     <= green_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            clearing_q  <= clearing_d;
        end
    end

    phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .tick    (tick),
        .count   (timer)
    );

    assign red         = red_q;
    assign yellow      = yellow_q;
    assign green       = green_q;
    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign clearing    = clearing_q;
    assign ped_pending = ped_q;
    assign active_slot = slot_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Table-driven bench for traffic_phase_ctrl (default parameters, 3 phases).
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [2:0] car_req;
    logic       ped_button;
    logic [2:0] red, yellow, green;
    logic       walk, dont_walk, clearing, ped_pending;
    logic [1:0] active_slot;

    int checks   = 0;
    int failures = 0;

`ifdef TRAFFIC_ALLRED_EN
    localparam int AR_CYC = 2;
`else
    localparam int AR_CYC = 0;
`endif

    traffic_phase_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tick        (tick),
        .car_req     (car_req),
        .ped_button  (ped_button),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .clearing    (clearing),
        .ped_pending (ped_pending),
        .active_slot (active_slot)
    );

    always #5 clock = ~clock;

    typedef enum int {K_IDLE, K_GRN, K_YEL, K_AR, K_WALK, K_CLR} kind_e;

    typedef struct {
        logic        rst_n;
        logic        tk;
        logic [2:0]  car;
        logic        ped;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected lamp word: {red, yellow, green, walk, dont_walk, clearing, ped_pending, slot}
    function automatic logic [14:0] lamps(kind_e k, int slot, logic pend);
        logic [2:0] r, y, g, one;
        logic       w, dw, c;
        one = 3'b001 << slot;
        r = 3'b111; y = 3'b000; g = 3'b000; w = 1'b0; dw = 1'b1; c = 1'b0;
        case (k)
            K_GRN:  begin g = one; r = ~one; end
            K_YEL:  begin y = one; r = ~one; end
            K_WALK: begin w = 1'b1; dw = 1'b0; end
            K_CLR:  c = 1'b1;
            default: ;
        endcase
        return {r, y, g, w, dw, c, pend, 2'(slot)};
    endfunction

    task automatic add(int n, logic rs, logic tk, logic [2:0] car, logic ped,
                       kind_e k, int slot, logic pend);
        vec_t v;
        v.rst_n = rs; v.tk = tk; v.car = car; v.ped = ped;
        v.exp = lamps(k, slot, pend);
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic s(int n, logic [2:0] car, kind_e k, int slot, logic pend);
        add(n, 1'b1, 1'b1, car, 1'b0, k, slot, pend);
    endtask

    task automatic ar(logic [2:0] car, int slot, logic pend);
        add(AR_CYC, 1'b1, 1'b1, car, 1'b0, K_AR, slot, pend);
    endtask

    task automatic chk(string name, logic [14:0] act, logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        checks++;
        if (($countones(green) > 1) || ((|green) && walk)) begin
            failures++;
            $display("FAIL conflict: green=%b walk=%b required at most one green and no green with walk",
                     green, walk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int k;
        reset_n    = 1'b0;
        tick       = 1'b1;
        car_req    = 3'b000;
        ped_button = 1'b0;

        // reset and idle
        add(2, 1'b0, 1'b1, 3'b000, 1'b0, K_IDLE, 3, 1'b0);
        s(20, 3'b000, K_IDLE, 3, 1'b0);
        // held request: max green, yellow, self re-pick, then early exit
        s(10, 3'b001, K_GRN, 0, 1'b0); s(3, 3'b001, K_YEL, 0, 1'b0); ar(3'b001, 0, 1'b0);
        s(1, 3'b001, K_GRN, 0, 1'b0);
        s(4, 3'b000, K_GRN, 0, 1'b0); s(3, 3'b000, K_YEL, 0, 1'b0); ar(3'b000, 0, 1'b0);
        s(2, 3'b000, K_IDLE, 3, 1'b0);
        // short pulse: minimum green
        s(2, 3'b010, K_GRN, 1, 1'b0); s(3, 3'b000, K_GRN, 1, 1'b0);
        s(3, 3'b000, K_YEL, 1, 1'b0); ar(3'b000, 1, 1'b0); s(2, 3'b000, K_IDLE, 3, 1'b0);
        // all phases plus pedestrian
        add(1, 1'b1, 1'b1, 3'b111, 1'b1, K_GRN, 0, 1'b1);
        s(9, 3'b111, K_GRN, 0, 1'b1); s(3, 3'b111, K_YEL, 0, 1'b1); ar(3'b111, 0, 1'b1);
        s(10, 3'b111, K_GRN, 1, 1'b1); s(3, 3'b111, K_YEL, 1, 1'b1); ar(3'b111, 1, 1'b1);
        s(10, 3'b111, K_GRN, 2, 1'b1); s(3, 3'b111, K_YEL, 2, 1'b1); ar(3'b111, 2, 1'b1);
        s(6, 3'b111, K_WALK, 3, 1'b0); s(4, 3'b111, K_CLR, 3, 1'b0); ar(3'b111, 3, 1'b0);
        s(1, 3'b111, K_GRN, 0, 1'b0);
        s(4, 3'b000, K_GRN, 0, 1'b0); s(3, 3'b000, K_YEL, 0, 1'b0); ar(3'b000, 0, 1'b0);
        s(2, 3'b000, K_IDLE, 3, 1'b0);
        // press coinciding with WALK entry is kept
        add(1, 1'b1, 1'b1, 3'b000, 1'b1, K_IDLE, 3, 1'b1);
        add(1, 1'b1, 1'b1, 3'b000, 1'b1, K_WALK, 3, 1'b1);
        s(5, 3'b000, K_WALK, 3, 1'b1); s(4, 3'b000, K_CLR, 3, 1'b1); ar(3'b000, 3, 1'b1);
        s(6, 3'b000, K_WALK, 3, 1'b0); s(4, 3'b000, K_CLR, 3, 1'b0); ar(3'b000, 3, 1'b0);
        s(2, 3'b000, K_IDLE, 3, 1'b0);
        // tick low: timed exits freeze, early green exit still fires
        s(10, 3'b001, K_GRN, 0, 1'b0);
        add(3, 1'b1, 1'b0, 3'b001, 1'b0, K_GRN, 0, 1'b0);
        add(1, 1'b1, 1'b0, 3'b000, 1'b0, K_YEL, 0, 1'b0);
        add(3, 1'b1, 1'b0, 3'b000, 1'b0, K_YEL, 0, 1'b0);
        s(2, 3'b000, K_YEL, 0, 1'b0); ar(3'b000, 0, 1'b0); s(2, 3'b000, K_IDLE, 3, 1'b0);
        // reset mid-yellow clears state and latch
        add(1, 1'b1, 1'b1, 3'b001, 1'b1, K_GRN, 0, 1'b1);
        s(9, 3'b001, K_GRN, 0, 1'b1); s(1, 3'b001, K_YEL, 0, 1'b1);
        add(1, 1'b0, 1'b1, 3'b001, 1'b0, K_IDLE, 3, 1'b0);
        s(1, 3'b000, K_IDLE, 3, 1'b0);
        s(10, 3'b001, K_GRN, 0, 1'b0); s(3, 3'b001, K_YEL, 0, 1'b0); ar(3'b001, 0, 1'b0);
        s(1, 3'b001, K_GRN, 0, 1'b0);
        s(4, 3'b000, K_GRN, 0, 1'b0); s(3, 3'b000, K_YEL, 0, 1'b0); ar(3'b000, 0, 1'b0);
        s(2, 3'b000, K_IDLE, 3, 1'b0);
        // round-robin wrap with a gap: 0 -> 2 -> 0
        s(10, 3'b101, K_GRN, 0, 1'b0); s(3, 3'b101, K_YEL, 0, 1'b0); ar(3'b101, 0, 1'b0);
        s(10, 3'b101, K_GRN, 2, 1'b0); s(3, 3'b101, K_YEL, 2, 1'b0); ar(3'b101, 2, 1'b0);
        s(1, 3'b101, K_GRN, 0, 1'b0);
        s(4, 3'b000, K_GRN, 0, 1'b0); s(3, 3'b000, K_YEL, 0, 1'b0); ar(3'b000, 0, 1'b0);
        s(2, 3'b000, K_IDLE, 3, 1'b0);

        foreach (tbl[i]) begin
            reset_n    = tbl[i].rst_n;
            tick       = tbl[i].tk;
            car_req    = tbl[i].car;
            ped_button = tbl[i].ped;
            step();
            chk($sformatf("vec%0d", i),
                {red, yellow, green, walk, dont_walk, clearing, ped_pending, active_slot},
                tbl[i].exp);
        end

        // measured phase lengths for a held request on phase 1
        reset_n = 1'b1; tick = 1'b1; ped_button = 1'b0;
        car_req = 3'b010;
        step();
        n = 0;
        while (green[1] === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk_int("green1_len", n, 10);
        car_req = 3'b000;
        m = 0;
        while (yellow[1] === 1'b1 && m < 40) begin
            m++;
            step();
        end
        chk_int("yellow1_len", m, 3);
        k = 0;
        while (!(active_slot == 2'd3 && red == 3'b111) && k < 10) begin
            k++;
            step();
        end
        chk_int("allred_then_idle_cycles", k, AR_CYC);
        chk_int("idle_slot", int'(active_slot), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-phase signalised-intersection controller. It generalises the fixed three-approach light FSMD with built-in phase timers, round-robin service across `NUM_PHASES` vehicle phases plus one pedestrian slot, and latched pedestrian requests. It sits between the debounced sensor/button inputs and the lamp drivers. All timing is counted in `tick` pulses from a shared prescaler.

## Interface
Parameters:
- `NUM_PHASES`, 3: vehicle phases; legal range 2..8.
- `TIMER_W`, 8: phase timer width.
- `GREEN_MIN`, 4: minimum green, in ticks.
- `GREEN_MAX`, 10: maximum green, in ticks. Must satisfy `GREEN_MIN < GREEN_MAX < 2**TIMER_W`.
- `YELLOW_TIME`, 3: yellow duration, in ticks (≥1).
- `WALK_TIME`, 6: walk duration, in ticks (≥1).
- `CLEAR_TIME`, 4: pedestrian clearance (flashing don't-walk), in ticks (≥1).
- `ALLRED_TIME`, 2: all-red interval, in ticks (≥1). Used only with `TRAFFIC_ALLRED_EN`.

Ports:
- `clock` in 1: single clock; all logic on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `tick` in 1: timebase enable, one-cycle pulse.
- `car_req` in `NUM_PHASES`: level vehicle presence, one bit per phase.
- `ped_button` in 1: pedestrian button, any width pulse.
- `red` out `NUM_PHASES`: per-phase red lamp.
- `yellow` out `NUM_PHASES`: per-phase yellow lamp.
- `green` out `NUM_PHASES`: per-phase green lamp.
- `walk` out 1: white walk lamp.
- `dont_walk` out 1: orange lamp.
- `clearing` out 1: high during pedestrian clearance; drives the flash of `dont_walk`.
- `ped_pending` out 1: pedestrian latch state.
- `active_slot` out `$clog2(NUM_PHASES+1)`: slot currently served. Values 0..N-1 are vehicle phases; N is the pedestrian slot.

## Operation
- States: IDLE, GREEN, YELLOW, ALLRED (only with the macro), WALK, CLEAR.
- Outputs are Moore-decoded from the registered state and `active_slot`.
  - IDLE/ALLRED: all `red`=1, `dont_walk`=1.
  - GREEN/YELLOW: only `green`/`yellow[active_slot]`=1; other `red`=1; `dont_walk`=1.
  - WALK: all red, `walk`=1, `dont_walk`=0.
  - CLEAR: all red, `dont_walk`=1, `clearing`=1.
- Reset values: state IDLE, `active_slot`=NUM_PHASES, timer 0, `ped_pending`=0. Lamps take the IDLE values: `red` all 1, `green`/`yellow`/`walk`/`clearing`=0, `dont_walk`=1.
- Request vector: `req = {ped_pending, car_req}`, NUM_PHASES+1 slots.
- Round-robin pick: the first set bit of `req`, scanning circularly from `active_slot+1` and wrapping, with `active_slot` itself checked last.
- IDLE: if any `req` bit is set, go to GREEN (vehicle pick) or WALK (slot N) and load `active_slot`.
- GREEN:
  - Go to YELLOW when (timer ≥ `GREEN_MIN` && `!car_req[active_slot]`).
  - Also go to YELLOW when (`tick` && timer == `GREEN_MAX-1`).
  - The max-green exit is unconditional, even if no other slot is requesting.
- YELLOW: on `tick` && timer == `YELLOW_TIME-1`, go to ALLRED if the macro is defined, else go straight to the pick.
- WALK: on `tick` && timer == `WALK_TIME-1`, go to CLEAR.
- CLEAR: on `tick` && timer == `CLEAR_TIME-1`, go to ALLRED or the pick.
- Pick with no request pending: go to IDLE and set `active_slot`=N.
- Pedestrian latch:
  - Set by `ped_button`; cleared on the cycle WALK is entered.
  - If set and clear coincide, set wins, so a press during the entry cycle is kept for the next cycle.
- Timer:
  - Cleared on every state transition.
  - Otherwise increments on `tick` and saturates at all-ones.

## Timing
- `car_req` and `ped_button` are sampled at the posedge. With `tick`=1, IDLE→GREEN lamps change one cycle after the request is first sampled high.
- With `tick` held high:
  - YELLOW lasts exactly `YELLOW_TIME` cycles; WALK, CLEAR and ALLRED likewise last their parameter values.
  - GREEN lasts between `GREEN_MIN+1` and `GREEN_MAX` cycles.
- Lamps never show green to two phases at once, or green together with `walk`, in any cycle.
- `reset_n` low mid-phase: IDLE outputs appear on the cycle after the sampling edge. Timer and latch are cleared.
- `tick` low: timed exits freeze. The GREEN early exit (min satisfied, request dropped) still fires.

## Configuration
- `TRAFFIC_ALLRED_EN` defined: ALLRED state is inserted after every YELLOW and CLEAR, lasting `ALLRED_TIME` ticks with all red and `dont_walk`=1.
- `TRAFFIC_ALLRED_EN` undefined: no ALLRED state; the pick is taken directly from YELLOW/CLEAR, and `ALLRED_TIME` is ignored.

## Structure
- `traffic_pkg`: state enum `tl_state_e`, and function `rr_pick(req, start)` returning slot index and valid.
- Sub-module `phase_timer`: `TIMER_W` saturating counter with `clear`/`tick` inputs and a `count` output.

## Test plan
Defaults apply, with `tick`=1 unless stated.
- Reset, `car_req`=0: all red, `dont_walk`=1, `active_slot`=3, state stays IDLE for 20 cycles.
- `car_req`=3'b001 held: green[0] stays high for 10 cycles, then yellow[0] for 3 cycles, then green[0] again (self re-pick).
- `car_req[1]` pulsed high for 2 cycles: green[1] lasts 5 cycles (`GREEN_MIN+1`), then yellow[1] lasts 3 cycles, then IDLE.
- `car_req`=3'b111 with `ped_button` pulsed: service order is 0→1→2→WALK. WALK lasts 6 cycles, CLEAR 4 cycles, then phase 0. `ped_pending` drops on WALK entry.
- `ped_button` pressed on the WALK entry cycle: `ped_pending` stays 1 and a second WALK follows on the next pedestrian turn.
- `reset_n` asserted mid-yellow with `TRAFFIC_ALLRED_EN` defined: IDLE next cycle. After reset, YELLOW is followed by 2 all-red cycles.
